// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the BCD stopwatch counter.
package stopwatch_pkg;

    typedef logic [3:0] bcd_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } sw_state_t;

    localparam bcd_t BCD_MAX = 4'd9;
    localparam bcd_t BCD_MIN = 4'd0;

    // Any non-decimal nibble saturates to 9.
    function automatic bcd_t bcd_clamp(input bcd_t d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit of the up/down chain: purely combinational next value and
// carry/borrow out.
module bcd_digit
    import stopwatch_pkg::*;
(
    input  bcd_t digit_i,
    input  logic up_i,
    input  logic cin_i,
    output bcd_t digit_o,
    output logic cout_o
);

    always_comb begin
        digit_o = digit_i;
        cout_o  = 1'b0;
        if (cin_i) begin
            if (up_i) begin
                if (digit_i >= BCD_MAX) begin
                    digit_o = BCD_MIN;
                    cout_o  = 1'b1;
                end else begin
                    digit_o = digit_i + 4'd1;
                end
            end else begin
                if (digit_i == BCD_MIN) begin
                    digit_o = BCD_MAX;
                    cout_o  = 1'b1;
                end else begin
                    digit_o = digit_i - 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/stopwatch_bcd_counter.sv
// Multi-digit BCD stopwatch: run-control FSM, tick prescaler and up/down digit chain.
// Optional lap capture register enabled by defining STOPWATCH_LAP_EN.
module stopwatch_bcd_counter
    import stopwatch_pkg::*;
#(
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned TICK_DIV = 1000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  clear,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   preset,
`ifdef STOPWATCH_LAP_EN
    input  logic                  lap,
    output logic [4*DIGITS-1:0]   lap_digits,
`endif
    output logic [4*DIGITS-1:0]   digits,
    output logic                  running,
    output logic                  done,
    output logic                  overflow
);

    localparam int unsigned DW = 4 * DIGITS;
    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    sw_state_t        state_q, state_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic [DW-1:0]    digits_q, digits_d;
    logic             running_q, running_d;
    logic             done_q, done_d;
    logic             overflow_q, overflow_d;
`ifdef STOPWATCH_LAP_EN
    logic [DW-1:0]    lap_q, lap_d;
`endif

    logic [DW-1:0]    digits_nxt;
    logic [DIGITS:0]  carry;
    logic [DW-1:0]    preset_clamped;
    logic             tick;

    assign carry[0] = 1'b1;
    assign tick     = (state_q == RUN) && (presc_q == PRESC_LAST);

    // Ripple chain: each stage sees carry/borrow from the stage below.
    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        bcd_digit u_digit (
            .digit_i (digits_q[4*i +: 4]),
            .up_i    (up),
            .cin_i   (carry[i]),
            .digit_o (digits_nxt[4*i +: 4]),
            .cout_o  (carry[i+1])
        );
    end

    always_comb begin
        preset_clamped = '0;
        for (int i = 0; i < DIGITS; i++) begin
            preset_clamped[4*i +: 4] = bcd_clamp(preset[4*i +: 4]);
        end
    end

    // Next-state: clear beats everything, then stop, start, load.
    always_comb begin
        state_d    = state_q;
        presc_d    = presc_q;
        digits_d   = digits_q;
        done_d     = 1'b0;
        overflow_d = 1'b0;

        if (clear) begin
            state_d  = IDLE;
            presc_d  = '0;
            digits_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    presc_d = '0;
                    if (!stop) begin
                        if (start) begin
                            if (up || (digits_q != '0)) state_d = RUN;
                        end else if (load) begin
                            digits_d = preset_clamped;
                        end
                    end
                end
                RUN: begin
                    if (stop) state_d = PAUSE;
                    if (tick) begin
                        presc_d = '0;
                        if (up) begin
                            digits_d   = digits_nxt;
                            overflow_d = carry[DIGITS];
                        end else if (digits_q == '0) begin
                            state_d = IDLE;
                        end else begin
                            digits_d = digits_nxt;
                            if (digits_nxt == '0) begin
                                done_d  = 1'b1;
                                state_d = IDLE;
                            end
                        end
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                end
                PAUSE: begin
                    if (!stop) begin
                        if (start) begin
                            if (up || (digits_q != '0)) state_d = RUN;
                        end else if (load) begin
                            digits_d = preset_clamped;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    presc_d = '0;
                end
            endcase
        end

        running_d = (state_d == RUN);
    end

`ifdef STOPWATCH_LAP_EN
    always_comb begin
        lap_d = lap_q;
        if (clear) begin
            lap_d = '0;
        end else if (lap && ((state_q == RUN) || (state_q == PAUSE))) begin
            lap_d = digits_q;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            presc_q    <= '0;
            digits_q   <= '0;
            running_q  <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            digits_q   <= digits_d;
            running_q  <= running_d;
            done_q     <= done_d;
            overflow_q <= overflow_d;
        end
    end

`ifdef STOPWATCH_LAP_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) lap_q <= '0;
        else       lap_q <= lap_d;
    end

    assign lap_digits = lap_q;
`endif

    assign digits   = digits_q;
    assign running  = running_q;
    assign done     = done_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_stopwatch_bcd_counter.sv
// Directed bench for stopwatch_bcd_counter with DIGITS=2, TICK_DIV=4.
// Lap capture checks are compiled in when STOPWATCH_LAP_EN is defined.
module tb_stopwatch_bcd_counter;

    localparam int unsigned DIGITS   = 2;
    localparam int unsigned TICK_DIV = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       clear = 1'b0;
    logic       up = 1'b1;
    logic       load = 1'b0;
    logic [7:0] preset = 8'h00;
    logic [7:0] digits;
    logic       running;
    logic       done;
    logic       overflow;
`ifdef STOPWATCH_LAP_EN
    logic       lap = 1'b0;
    logic [7:0] lap_digits;
`endif

    int n_vec = 0;
    int n_err = 0;

    stopwatch_bcd_counter #(
        .DIGITS   (DIGITS),
        .TICK_DIV (TICK_DIV)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .stop       (stop),
        .clear      (clear),
        .up         (up),
        .load       (load),
        .preset     (preset),
`ifdef STOPWATCH_LAP_EN
        .lap        (lap),
        .lap_digits (lap_digits),
`endif
        .digits     (digits),
        .running    (running),
        .done       (done),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step(1);
        clear = 1'b0;
    endtask

    task automatic do_load(input logic [7:0] val);
        preset = val;
        load   = 1'b1;
        step(1);
        load   = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic test_reset();
        #2 reset = 1'b1;
        step(2);
        n_vec++; if (digits !== 8'h00) begin n_err++; $display("FAIL reset_digits: got %h expected %h", digits, 8'h00); end
        n_vec++; if (running !== 1'b0) begin n_err++; $display("FAIL reset_running: got %b expected %b", running, 1'b0); end
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected %b", done, 1'b0); end
        n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow: got %b expected %b", overflow, 1'b0); end
        reset = 1'b0;
        step(1);
    endtask

    task automatic test_count_up();
        up = 1'b1;
        do_start();
        n_vec++; if (running !== 1'b1) begin n_err++; $display("FAIL up_running: got %b expected %b", running, 1'b1); end
        step(3);
        n_vec++; if (digits !== 8'h00) begin n_err++; $display("FAIL up_pre_tick: got %h expected %h", digits, 8'h00); end
        step(1);
        n_vec++; if (digits !== 8'h01) begin n_err++; $display("FAIL up_first_tick: got %h expected %h", digits, 8'h01); end
        step(36);
        n_vec++; if (digits !== 8'h10) begin n_err++; $display("FAIL up_ten_ticks: got %h expected %h", digits, 8'h10); end
    endtask

    task automatic test_overflow();
        do_clear();
        up = 1'b1;
        do_load(8'h99);
        n_vec++; if (digits !== 8'h99) begin n_err++; $display("FAIL ovf_load: got %h expected %h", digits, 8'h99); end
        do_start();
        step(3);
        n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_early: got %b expected %b", overflow, 1'b0); end
        step(1);
        n_vec++; if (digits !== 8'h00) begin n_err++; $display("FAIL ovf_wrap: got %h expected %h", digits, 8'h00); end
        n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_pulse: got %b expected %b", overflow, 1'b1); end
        n_vec++; if (running !== 1'b1) begin n_err++; $display("FAIL ovf_running: got %b expected %b", running, 1'b1); end
        step(1);
        n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_one_cycle: got %b expected %b", overflow, 1'b0); end
        n_vec++; if (running !== 1'b1) begin n_err++; $display("FAIL ovf_continue: got %b expected %b", running, 1'b1); end
    endtask

    task automatic test_count_down();
        do_clear();
        up = 1'b0;
        do_load(8'h02);
        do_start();
        step(3);
        n_vec++; if (digits !== 8'h02) begin n_err++; $display("FAIL dn_hold: got %h expected %h", digits, 8'h02); end
        step(1);
        n_vec++; if (digits !== 8'h01) begin n_err++; $display("FAIL dn_first: got %h expected %h", digits, 8'h01); end
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL dn_no_done: got %b expected %b", done, 1'b0); end
        step(4);
        n_vec++; if (digits !== 8'h00) begin n_err++; $display("FAIL dn_zero: got %h expected %h", digits, 8'h00); end
        n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL dn_done: got %b expected %b", done, 1'b1); end
        n_vec++; if (running !== 1'b0) begin n_err++; $display("FAIL dn_stopped: got %b expected %b", running, 1'b0); end
        step(1);
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL dn_done_one_cycle: got %b expected %b", done, 1'b0); end
        do_start();
        n_vec++; if (running !== 1'b0) begin n_err++; $display("FAIL dn_restart_zero: got %b expected %b", running, 1'b0); end
        step(4);
        n_vec++; if (digits !== 8'h00) begin n_err++; $display("FAIL dn_stay_zero: got %h expected %h", digits, 8'h00); end
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL dn_no_redone: got %b expected %b", done, 1'b0); end
    endtask

    task automatic test_borrow_clamp();
        do_clear();
        up = 1'b0;
        do_load(8'h10);
        do_start();
        step(4);
        n_vec++; if (digits !== 8'h09) begin n_err++; $display("FAIL borrow: got %h expected %h", digits, 8'h09); end
        do_load(8'h55);
        n_vec++; if (digits !== 8'h09) begin n_err++; $display("FAIL load_in_run: got %h expected %h", digits, 8'h09); end
        do_clear();
        do_load(8'hAF);
        n_vec++; if (digits !== 8'h99) begin n_err++; $display("FAIL clamp: got %h expected %h", digits, 8'h99); end
        do_load(8'h3C);
        n_vec++; if (digits !== 8'h39) begin n_err++; $display("FAIL clamp_low: got %h expected %h", digits, 8'h39); end
    endtask

    task automatic test_stop_resume();
        do_clear();
        up = 1'b1;
        do_start();
        step(2);
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        n_vec++; if (running !== 1'b0) begin n_err++; $display("FAIL pause_running: got %b expected %b", running, 1'b0); end
        step(5);
        n_vec++; if (digits !== 8'h00) begin n_err++; $display("FAIL pause_frozen: got %h expected %h", digits, 8'h00); end
        do_start();
        n_vec++; if (running !== 1'b1) begin n_err++; $display("FAIL resume_running: got %b expected %b", running, 1'b1); end
        n_vec++; if (digits !== 8'h00) begin n_err++; $display("FAIL resume_hold: got %h expected %h", digits, 8'h00); end
        step(1);
        n_vec++; if (digits !== 8'h01) begin n_err++; $display("FAIL resume_tick: got %h expected %h", digits, 8'h01); end
        clear = 1'b1;
        start = 1'b1;
        step(1);
        clear = 1'b0;
        start = 1'b0;
        n_vec++; if (running !== 1'b0) begin n_err++; $display("FAIL clear_start_running: got %b expected %b", running, 1'b0); end
        n_vec++; if (digits !== 8'h00) begin n_err++; $display("FAIL clear_start_digits: got %h expected %h", digits, 8'h00); end
        step(5);
        n_vec++; if (digits !== 8'h00) begin n_err++; $display("FAIL clear_idle_digits: got %h expected %h", digits, 8'h00); end
    endtask

    task automatic test_async_reset();
        do_clear();
        up = 1'b1;
        do_start();
        step(4);
        n_vec++; if (digits !== 8'h01) begin n_err++; $display("FAIL rst_pre: got %h expected %h", digits, 8'h01); end
        #3 reset = 1'b1;
        #1;
        n_vec++; if (digits !== 8'h00) begin n_err++; $display("FAIL rst_async_digits: got %h expected %h", digits, 8'h00); end
        n_vec++; if (running !== 1'b0) begin n_err++; $display("FAIL rst_async_running: got %b expected %b", running, 1'b0); end
        #1 reset = 1'b0;
        @(posedge clk);
        #1;
        step(4);
        n_vec++; if (digits !== 8'h00) begin n_err++; $display("FAIL rst_idle: got %h expected %h", digits, 8'h00); end
    endtask

`ifdef STOPWATCH_LAP_EN
    task automatic test_lap();
        do_clear();
        up = 1'b1;
        do_load(8'h37);
        do_start();
        lap = 1'b1;
        step(1);
        lap = 1'b0;
        n_vec++; if (lap_digits !== 8'h37) begin n_err++; $display("FAIL lap_capture: got %h expected %h", lap_digits, 8'h37); end
        step(3);
        n_vec++; if (digits !== 8'h38) begin n_err++; $display("FAIL lap_advance: got %h expected %h", digits, 8'h38); end
        n_vec++; if (lap_digits !== 8'h37) begin n_err++; $display("FAIL lap_hold: got %h expected %h", lap_digits, 8'h37); end
        do_clear();
        n_vec++; if (lap_digits !== 8'h00) begin n_err++; $display("FAIL lap_clear: got %h expected %h", lap_digits, 8'h00); end
    endtask
`endif

    initial begin
        test_reset();
        test_count_up();
        test_overflow();
        test_count_down();
        test_borrow_clamp();
        test_stop_resume();
        test_async_reset();
`ifdef STOPWATCH_LAP_EN
        test_lap();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
